uart_fetch_ctrl: RTL

//  Fetch controller feeding the UART instruction interface. Accepts a word-address fetch

---
 rtl/uart_fetch_ctrl_if.sv | 25 ++
 rtl/uart_fetch_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/uart_fetch_ctrl_if.sv
// Core/UART-side bundle of the fetch controller: request, query strobe, returned word, response.
// master = core + UART model side, slave = controller.
interface uart_fetch_ctrl_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        instr_query;
    logic [31:0] query_addr;
    logic        uart_word_valid;
    logic [31:0] uart_word;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;

    modport master (
        output fetch_req, fetch_addr, uart_word_valid, uart_word, rsp_ready,
        input  fetch_ready, instr_query, query_addr, rsp_valid, rsp_instr, rsp_err
    );

    modport slave (
        input  fetch_req, fetch_addr, uart_word_valid, uart_word, rsp_ready,
        output fetch_ready, instr_query, query_addr, rsp_valid, rsp_instr, rsp_err
    );
endinterface

// File: rtl/uart_fetch_ctrl.sv
// Fetch controller: holds a query long enough for the slow UART transmitter, waits for the
// returned word with timeout and bounded retry, and hands the result back on valid/ready.
module uart_fetch_ctrl #(
    parameter int QUERY_HOLD = 400,
    parameter int TIMEOUT    = 2_000_000,
    parameter int MAX_RETRY  = 3
) (
    input  logic              clk,
    input  logic              reset,
    uart_fetch_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_QUERY = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int HW = $clog2(QUERY_HOLD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(QUERY_HOLD - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic [1:0]    r_state;
    logic [HW-1:0] r_hold;
    logic [TW-1:0] r_tmo;
    logic [RW-1:0] r_retry;
    logic          r_fetch_ready;
    logic          r_instr_query;
    logic [31:0]   r_query_addr;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_instr;
    logic          r_rsp_err;

    assign bus.fetch_ready = r_fetch_ready;
    assign bus.instr_query = r_instr_query;
    assign bus.query_addr  = r_query_addr;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_instr   = r_rsp_instr;
    assign bus.rsp_err     = r_rsp_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_hold        <= '0;
            r_tmo         <= '0;
            r_retry       <= '0;
            r_fetch_ready <= 1'b1;
            r_instr_query <= 1'b0;
            r_query_addr  <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_instr   <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.fetch_req && r_fetch_ready) begin
                        r_fetch_ready <= 1'b0;
                        // Misaligned requests never reach the UART; report straight away.
                        if (bus.fetch_addr[1:0] != 2'b00) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_instr <= '0;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state       <= S_QUERY;
                            r_query_addr  <= bus.fetch_addr;
                            r_instr_query <= 1'b1;
                            r_hold        <= '0;
                            r_retry       <= '0;
                        end
                    end
                end
                S_QUERY: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state       <= S_WAIT;
                        r_instr_query <= 1'b0;
                        r_tmo         <= '0;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_WAIT: begin
                    // A word arriving on the timeout cycle still counts.
                    if (bus.uart_word_valid) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_instr <= bus.uart_word;
                        r_rsp_err   <= 1'b0;
                    end else if (r_tmo == TMO_LAST) begin
                        if (r_retry == RETRY_MAX) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_instr <= '0;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state       <= S_QUERY;
                            r_retry       <= r_retry + 1'b1;
                            r_instr_query <= 1'b1;
                            r_hold        <= '0;
                        end
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state       <= S_IDLE;
                        r_rsp_valid   <= 1'b0;
                        r_fetch_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
